demux_1x4_stream: RTL and testbench

- Registered 1-to-4 demultiplexer with valid/ready handshake on every side.
- Routes each accepted input word to one of four output slots, chosen by a 2-bit select.
- Each output slot holds its word until that destination accepts it.
- Sits on the datapath write side, distributing ALU/accumulator results to up to four destinations, e.g. accumulator, memory data register, output port, PC.

---
 rtl/demux_1x4_stream.sv | 119 +++++++++++
 tb/tb_demux_1x4_stream.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/demux_1x4_stream.sv
`default_nettype none
// ============================================================================
// Module      : demux_1x4_stream
// Description : Registered 1-to-4 stream demultiplexer with valid/ready
//               handshake on the input and on each of the four output slots.
//               Each accepted word is routed to the slot chosen by in_select
//               and held there until that destination takes it.
//               Optional broadcast mode, enabled by defining DEMUX_BCAST_EN,
//               adds an in_bcast input that loads a word into all four slots.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_1x4_stream #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
`ifdef DEMUX_BCAST_EN
    input  logic             in_bcast,
`endif
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_select,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data_0,
    output logic [WIDTH-1:0] out_data_1,
    output logic [WIDTH-1:0] out_data_2,
    output logic [WIDTH-1:0] out_data_3,
    output logic             out_valid_0,
    output logic             out_valid_1,
    output logic             out_valid_2,
    output logic             out_valid_3,
    input  logic             out_ready_0,
    input  logic             out_ready_1,
    input  logic             out_ready_2,
    input  logic             out_ready_3,
    output logic [3:0]       pending,
    output logic [7:0]       accept_count
);

    localparam logic [3:0] c_ALL_SLOTS = 4'b1111;

    logic [WIDTH-1:0] r_data [4];
    logic [3:0]       r_valid;
    logic [7:0]       r_count;

    logic [3:0]       w_out_ready;
    logic [3:0]       w_slot_free;
    logic [3:0]       w_sel_onehot;
    logic [3:0]       w_target;
    logic             w_in_ready;
    logic             w_accept;
    logic [3:0]       w_load;
    logic [3:0]       w_drain;

    assign w_out_ready  = {out_ready_3, out_ready_2, out_ready_1, out_ready_0};

    // A slot can take a new word if it is empty or being drained this cycle,
    // which gives pass-through ready and full throughput into one slot.
    assign w_slot_free  = ~r_valid | w_out_ready;
    assign w_sel_onehot = 4'b0001 << in_select;

    // Ready looks only at the slot(s) being targeted, so a stalled
    // unselected slot never blocks traffic to the others.
    always_comb begin
        w_target   = w_sel_onehot;
        w_in_ready = ~reset & w_slot_free[in_select];
`ifdef DEMUX_BCAST_EN
        if (in_bcast) begin
            w_target   = c_ALL_SLOTS;
            w_in_ready = ~reset & (&w_slot_free);
        end
`endif
    end

    assign w_accept = in_valid & w_in_ready;
    assign w_load   = {4{w_accept}} & w_target;
    assign w_drain  = r_valid & w_out_ready;

    generate
        for (genvar k = 0; k < 4; k++) begin : g_slot
            // Slot register: a load beats a drain so drain+reload keeps valid high;
            // data is left untouched on drain.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_data[k]  <= '0;
                    r_valid[k] <= 1'b0;
                end else if (w_load[k]) begin
                    r_data[k]  <= in_data;
                    r_valid[k] <= 1'b1;
                end else if (w_drain[k]) begin
                    r_valid[k] <= 1'b0;
                end
            end
        end
    endgenerate

    // Accepted-word counter; one count per accept even when broadcasting.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign in_ready     = w_in_ready;
    assign out_data_0   = r_data[0];
    assign out_data_1   = r_data[1];
    assign out_data_2   = r_data[2];
    assign out_data_3   = r_data[3];
    assign out_valid_0  = r_valid[0];
    assign out_valid_1  = r_valid[1];
    assign out_valid_2  = r_valid[2];
    assign out_valid_3  = r_valid[3];
    assign pending      = r_valid & c_ALL_SLOTS;
    assign accept_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_demux_1x4_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_1x4_stream
// Description : Directed self-checking bench for demux_1x4_stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_1x4_stream;

    logic       clk;
    logic       reset;
    logic       in_bcast;
    logic [7:0] in_data;
    logic [1:0] in_select;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data_0, out_data_1, out_data_2, out_data_3;
    logic       out_valid_0, out_valid_1, out_valid_2, out_valid_3;
    logic       out_ready_0, out_ready_1, out_ready_2, out_ready_3;
    logic [3:0] pending;
    logic [7:0] accept_count;

    int total_cnt = 0;
    int bad_cnt   = 0;

    demux_1x4_stream #(.WIDTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
`ifdef DEMUX_BCAST_EN
        .in_bcast     (in_bcast),
`endif
        .in_data      (in_data),
        .in_select    (in_select),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data_0   (out_data_0),
        .out_data_1   (out_data_1),
        .out_data_2   (out_data_2),
        .out_data_3   (out_data_3),
        .out_valid_0  (out_valid_0),
        .out_valid_1  (out_valid_1),
        .out_valid_2  (out_valid_2),
        .out_valid_3  (out_valid_3),
        .out_ready_0  (out_ready_0),
        .out_ready_1  (out_ready_1),
        .out_ready_2  (out_ready_2),
        .out_ready_3  (out_ready_3),
        .pending      (pending),
        .accept_count (accept_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ready(input logic [3:0] r);
        {out_ready_3, out_ready_2, out_ready_1, out_ready_0} = r;
    endtask

    initial begin
        reset     = 1'b1;
        in_bcast  = 1'b0;
        in_data   = 8'h00;
        in_select = 2'd0;
        in_valid  = 1'b1;
        set_ready(4'b0000);

        // Reset then idle
        step();
        step();
        #1;
        check_val("rst_in_ready", in_ready, 0);
        check_val("rst_pending", pending, 4'b0000);
        check_val("rst_count", accept_count, 0);
        check_val("rst_data", {out_data_3, out_data_2, out_data_1, out_data_0}, 32'h0);
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        check_val("idle_in_ready", in_ready, 1);

        // Single route to slot 2
        in_data = 8'hA5; in_select = 2'd2; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check_val("r2_valid", out_valid_2, 1);
        check_val("r2_data", out_data_2, 8'hA5);
        check_val("r2_pending", pending, 4'b0100);
        check_val("r2_count", accept_count, 1);
        set_ready(4'b0100);
        step();
        set_ready(4'b0000);
        check_val("r2_drained", pending, 4'b0000);
        check_val("r2_data_kept", out_data_2, 8'hA5);

        // Back-pressure isolation
        in_data = 8'h11; in_select = 2'd1; in_valid = 1'b1;
        step();
        in_data = 8'h22; in_select = 2'd1;
        #1;
        check_val("bp_blocked", in_ready, 0);
        step();
        check_val("bp_hold1", out_data_1, 8'h11);
        check_val("bp_count_held", accept_count, 2);
        in_data = 8'h33; in_select = 2'd3;
        #1;
        check_val("bp_other_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        check_val("bp_data3", out_data_3, 8'h33);
        check_val("bp_data1", out_data_1, 8'h11);
        check_val("bp_pending", pending, 4'b1010);
        check_val("bp_count", accept_count, 3);
        set_ready(4'b1010);
        step();
        set_ready(4'b0000);
        check_val("bp_drained", pending, 4'b0000);

        // Streaming with simultaneous drain/reload into slot 0
        set_ready(4'b0001);
        in_select = 2'd0;
        for (int i = 1; i <= 5; i++) begin
            in_data  = 8'(i);
            in_valid = 1'b1;
            #1;
            check_val("st_ready", in_ready, 1);
            step();
            check_val("st_data", out_data_0, i);
            check_val("st_valid", out_valid_0, 1);
        end
        in_valid = 1'b0;
        step();
        check_val("st_count", accept_count, 8);
        check_val("st_empty", pending, 4'b0000);

        // Counter wrap with all destinations ready
        set_ready(4'b1111);
        in_valid = 1'b1;
        for (int i = 0; i < 248; i++) begin
            in_data = 8'(i); in_select = 2'(i % 4);
            step();
        end
        check_val("wrap_zero", accept_count, 0);
        in_data = 8'hEE; in_select = 2'd2;
        step();
        in_valid = 1'b0;
        check_val("wrap_one", accept_count, 1);
        check_val("wrap_data2", out_data_2, 8'hEE);
        step();
        set_ready(4'b0000);
        check_val("wrap_drained", pending, 4'b0000);

        // Reset mid-operation with a simultaneous accept
        in_valid = 1'b1;
        in_data = 8'h10; in_select = 2'd0;
        step();
        in_data = 8'h30; in_select = 2'd3;
        step();
        check_val("mid_pending", pending, 4'b1001);
        reset = 1'b1; in_data = 8'h77; in_select = 2'd1;
        step();
        reset = 1'b0; in_valid = 1'b0;
        check_val("mid_rst_pending", pending, 4'b0000);
        check_val("mid_rst_count", accept_count, 0);
        check_val("mid_rst_data1", out_data_1, 0);
        check_val("mid_rst_data0", out_data_0, 0);
        set_ready(4'b1111);
        step();
        set_ready(4'b0000);
        check_val("mid_rst_still", pending, 4'b0000);

`ifdef DEMUX_BCAST_EN
        // Broadcast into all four empty slots
        in_bcast = 1'b1; in_data = 8'h5A; in_select = 2'd1; in_valid = 1'b1;
        #1;
        check_val("bc_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        check_val("bc_pending", pending, 4'b1111);
        check_val("bc_data", {out_data_3, out_data_2, out_data_1, out_data_0}, 32'h5A5A5A5A);
        check_val("bc_count", accept_count, 1);
        set_ready(4'b1011);
        in_valid = 1'b1; in_data = 8'h6B;
        #1;
        check_val("bc_blocked", in_ready, 0);
        in_valid = 1'b0; in_bcast = 1'b0;
        set_ready(4'b0000);
`endif

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
`default_nettype wire
